// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT table builder and its code generator.
package dht_pkg;

  localparam int CODE_LENGTH  = 16;
  localparam int DC_VVEC_SIZE = 12;
  localparam int AC_VVEC_SIZE = 162;
  localparam int AC_RUNS      = 16;
  localparam int MAX_AC_SIZE  = 10;

  localparam logic [3:0] TC_DC   = 4'd0;
  localparam logic [3:0] TC_AC   = 4'd1;
  localparam logic [7:0] SYM_EOB = 8'h00;
  localparam logic [7:0] SYM_ZRL = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BITS    = 3'd1,
    ST_NEXTLEN = 3'd2,
    ST_VALS    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // A code equal to all ones of its length would be a prefix of nothing valid.
  function automatic logic [16:0] all_ones(input logic [4:0] len);
    all_ones = (17'd1 << len) - 17'd1;
  endfunction

endpackage

// File: rtl/dht_if.sv
// Huffman code/length tables handed from the table builder to the entropy coder.
interface dht_if;
  import dht_pkg::*;

  logic [15:0] y_dc_huffcode  [DC_VVEC_SIZE];
  logic [7:0]  y_dc_huffsize  [DC_VVEC_SIZE];
  logic [15:0] uv_dc_huffcode [DC_VVEC_SIZE];
  logic [7:0]  uv_dc_huffsize [DC_VVEC_SIZE];
  logic [15:0] y_ac_huffcode  [AC_RUNS][MAX_AC_SIZE];
  logic [7:0]  y_ac_huffsize  [AC_RUNS][MAX_AC_SIZE];
  logic [15:0] uv_ac_huffcode [AC_RUNS][MAX_AC_SIZE];
  logic [7:0]  uv_ac_huffsize [AC_RUNS][MAX_AC_SIZE];
  logic [15:0] y_eob;
  logic [7:0]  y_eob_len;
  logic [15:0] y_zrl;
  logic [7:0]  y_zrl_len;
  logic [15:0] uv_eob;
  logic [7:0]  uv_eob_len;
  logic [15:0] uv_zrl;
  logic [7:0]  uv_zrl_len;

  modport master (
    output y_dc_huffcode, y_dc_huffsize, uv_dc_huffcode, uv_dc_huffsize,
    output y_ac_huffcode, y_ac_huffsize, uv_ac_huffcode, uv_ac_huffsize,
    output y_eob, y_eob_len, y_zrl, y_zrl_len,
    output uv_eob, uv_eob_len, uv_zrl, uv_zrl_len
  );

  modport slave (
    input y_dc_huffcode, y_dc_huffsize, uv_dc_huffcode, uv_dc_huffsize,
    input y_ac_huffcode, y_ac_huffsize, uv_ac_huffcode, uv_ac_huffsize,
    input y_eob, y_eob_len, y_zrl, y_zrl_len,
    input uv_eob, uv_eob_len, uv_zrl, uv_zrl_len
  );

endinterface

// File: rtl/dht_code_gen.sv
// Canonical Huffman code counter: walks code lengths and hands out consecutive
// codes while the builder consumes HUFFVAL symbols.
module dht_code_gen
  import dht_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        step_i,
  input  logic        use_i,
  input  logic [7:0]  bits_next_i,
  output logic [4:0]  len_o,
  output logic [16:0] code_o,
  output logic [7:0]  rem_o,
  output logic        code_bad_o
);

  logic [4:0]  len_q,  len_d;
  logic [16:0] code_q, code_d;
  logic [7:0]  rem_q,  rem_d;

  // Next-state for length, code and remaining-at-this-length counters
  always_comb begin
    len_d  = len_q;
    code_d = code_q;
    rem_d  = rem_q;
    if (init_i) begin
      len_d  = 5'd0;
      code_d = 17'd0;
      rem_d  = 8'd0;
    end else if (step_i) begin
      len_d  = len_q + 5'd1;
      code_d = {code_q[15:0], 1'b0};
      rem_d  = bits_next_i;
    end else if (use_i) begin
      code_d = code_q + 17'd1;
      rem_d  = rem_q - 8'd1;
    end else begin
      rem_d  = rem_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= 5'd0;
      code_q <= 17'd0;
      rem_q  <= 8'd0;
    end else begin
      len_q  <= len_d;
      code_q <= code_d;
      rem_q  <= rem_d;
    end
  end

  assign len_o      = len_q;
  assign code_o     = code_q;
  assign rem_o      = rem_q;
  assign code_bad_o = code_q[16] | (code_q == all_ones(len_q));

endmodule

// File: rtl/dht_table_builder.sv
// Parses one DHT table packet ({Tc,Th}, BITS[16], HUFFVAL) and writes the
// resulting code/length tables for the entropy coder.
module dht_table_builder
  import dht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  dht_if.master      dht,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t      state_q, state_d;
  logic        err_q, err_d, tc_q, tc_d, th_q, th_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  total_q, total_d, total_sum_s, total_max_s;
  logic [7:0]  bits_q [CODE_LENGTH];
  logic        bits_wr_s, acc_s, rdy_q, busy_q, done_q;
  logic        cg_init_s, cg_step_s, cg_use_s, cg_bad_s;
  logic [4:0]  cg_len_s;
  logic [16:0] cg_code_s;
  logic [7:0]  cg_rem_s, bits_next_s;
  logic        sym_ok_s, is_eob_s, is_zrl_s, wr_en_s;
  logic [3:0]  sym_run_s, sym_size_s, ac_col_s;

  logic [15:0] dc_code_q [2][DC_VVEC_SIZE];
  logic [7:0]  dc_len_q  [2][DC_VVEC_SIZE];
  logic [15:0] ac_code_q [2][AC_RUNS][MAX_AC_SIZE];
  logic [7:0]  ac_len_q  [2][AC_RUNS][MAX_AC_SIZE];
  logic [15:0] eob_code_q [2];
  logic [7:0]  eob_len_q  [2];
  logic [15:0] zrl_code_q [2];
  logic [7:0]  zrl_len_q  [2];

  assign acc_s       = s_tvalid & rdy_q;
  assign total_sum_s = total_q + s_tdata;
  assign total_max_s = tc_q ? 8'(AC_VVEC_SIZE) : 8'(DC_VVEC_SIZE);
  assign bits_next_s = (cg_len_s < 5'd16) ? bits_q[cg_len_s[3:0]] : 8'd0;

  dht_code_gen u_code_gen (
    .clk         (clk),
    .rst         (rst),
    .init_i      (cg_init_s),
    .step_i      (cg_step_s),
    .use_i       (cg_use_s),
    .bits_next_i (bits_next_s),
    .len_o       (cg_len_s),
    .code_o      (cg_code_s),
    .rem_o       (cg_rem_s),
    .code_bad_o  (cg_bad_s)
  );

  // Symbol decode for the table selected by the header
  always_comb begin
    sym_run_s  = s_tdata[7:4];
    sym_size_s = s_tdata[3:0];
    ac_col_s   = sym_size_s - 4'd1;
    is_eob_s   = tc_q & (s_tdata == SYM_EOB);
    is_zrl_s   = tc_q & (s_tdata == SYM_ZRL);
    if (!tc_q) begin
      sym_ok_s = (s_tdata < 8'(DC_VVEC_SIZE));
    end else begin
      sym_ok_s = is_eob_s | is_zrl_s |
                 ((sym_size_s != 4'd0) && (sym_size_s <= 4'(MAX_AC_SIZE)));
    end
  end

  // Packet FSM: next state, error flag and datapath strobes
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    tc_d      = tc_q;
    th_d      = th_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    bits_wr_s = 1'b0;
    cg_init_s = 1'b0;
    cg_step_s = 1'b0;
    cg_use_s  = 1'b0;
    wr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_s) begin
          if ((s_tdata[7:4] > TC_AC) || (s_tdata[3:0] > 4'd1) || s_tlast) begin
            err_d   = 1'b1;
            state_d = s_tlast ? ST_IDLE : ST_DRAIN;
          end else begin
            err_d   = 1'b0;
            tc_d    = s_tdata[4];
            th_d    = s_tdata[0];
            cnt_d   = 4'd0;
            total_d = 8'd0;
            state_d = ST_BITS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BITS: begin
        if (acc_s) begin
          bits_wr_s = 1'b1;
          total_d   = total_sum_s;
          cnt_d     = cnt_q + 4'd1;
          if (s_tlast) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == 4'd15) begin
            if ((total_sum_s == 8'd0) || (total_sum_s > total_max_s)) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              cg_init_s = 1'b1;
              state_d   = ST_NEXTLEN;
            end
          end else begin
            state_d = ST_BITS;
          end
        end else begin
          state_d = ST_BITS;
        end
      end
      ST_NEXTLEN: begin
        // Guard against running off the end of BITS when the total wrapped
        if (cg_len_s == 5'd16) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cg_step_s = 1'b1;
          state_d   = (bits_next_s != 8'd0) ? ST_VALS : ST_NEXTLEN;
        end
      end
      ST_VALS: begin
        if (acc_s) begin
          if (!sym_ok_s || cg_bad_s) begin
            err_d   = 1'b1;
            state_d = s_tlast ? ST_IDLE : ST_DRAIN;
          end else begin
            wr_en_s  = 1'b1;
            cg_use_s = 1'b1;
            total_d  = total_q - 8'd1;
            if (total_q == 8'd1) begin
              err_d   = ~s_tlast | err_q;
              state_d = s_tlast ? ST_DONE : ST_DRAIN;
            end else if (s_tlast) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else if (cg_rem_s == 8'd1) begin
              state_d = ST_NEXTLEN;
            end else begin
              state_d = ST_VALS;
            end
          end
        end else begin
          state_d = ST_VALS;
        end
      end
      ST_DRAIN: begin
        if (acc_s && s_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      tc_q    <= 1'b0;
      th_q    <= 1'b0;
      cnt_q   <= 4'd0;
      total_q <= 8'd0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < CODE_LENGTH; i++) bits_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tc_q    <= tc_d;
      th_q    <= th_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      if (bits_wr_s) bits_q[cnt_q] <= s_tdata;
      rdy_q   <= (state_d == ST_IDLE) || (state_d == ST_BITS) ||
                 (state_d == ST_VALS) || (state_d == ST_DRAIN);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Table storage; index 0 is luminance (Th=0), index 1 chrominance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < 2; t++) begin
        eob_code_q[t] <= 16'd0;
        eob_len_q[t]  <= 8'd0;
        zrl_code_q[t] <= 16'd0;
        zrl_len_q[t]  <= 8'd0;
        for (int i = 0; i < DC_VVEC_SIZE; i++) begin
          dc_code_q[t][i] <= 16'd0;
          dc_len_q[t][i]  <= 8'd0;
        end
        for (int r = 0; r < AC_RUNS; r++) begin
          for (int c = 0; c < MAX_AC_SIZE; c++) begin
            ac_code_q[t][r][c] <= 16'd0;
            ac_len_q[t][r][c]  <= 8'd0;
          end
        end
      end
    end else if (wr_en_s) begin
      if (!tc_q) begin
        dc_code_q[th_q][s_tdata[3:0]] <= cg_code_s[15:0];
        dc_len_q[th_q][s_tdata[3:0]]  <= {3'b000, cg_len_s};
      end else if (is_eob_s) begin
        eob_code_q[th_q] <= cg_code_s[15:0];
        eob_len_q[th_q]  <= {3'b000, cg_len_s};
      end else if (is_zrl_s) begin
        zrl_code_q[th_q] <= cg_code_s[15:0];
        zrl_len_q[th_q]  <= {3'b000, cg_len_s};
      end else begin
        ac_code_q[th_q][sym_run_s][ac_col_s] <= cg_code_s[15:0];
        ac_len_q[th_q][sym_run_s][ac_col_s]  <= {3'b000, cg_len_s};
      end
    end
  end

  for (genvar i = 0; i < DC_VVEC_SIZE; i++) begin : g_dc
    assign dht.y_dc_huffcode[i]  = dc_code_q[0][i];
    assign dht.y_dc_huffsize[i]  = dc_len_q[0][i];
    assign dht.uv_dc_huffcode[i] = dc_code_q[1][i];
    assign dht.uv_dc_huffsize[i] = dc_len_q[1][i];
  end

  for (genvar r = 0; r < AC_RUNS; r++) begin : g_ac_run
    for (genvar c = 0; c < MAX_AC_SIZE; c++) begin : g_ac_size
      assign dht.y_ac_huffcode[r][c]  = ac_code_q[0][r][c];
      assign dht.y_ac_huffsize[r][c]  = ac_len_q[0][r][c];
      assign dht.uv_ac_huffcode[r][c] = ac_code_q[1][r][c];
      assign dht.uv_ac_huffsize[r][c] = ac_len_q[1][r][c];
    end
  end

  assign dht.y_eob      = eob_code_q[0];
  assign dht.y_eob_len  = eob_len_q[0];
  assign dht.y_zrl      = zrl_code_q[0];
  assign dht.y_zrl_len  = zrl_len_q[0];
  assign dht.uv_eob     = eob_code_q[1];
  assign dht.uv_eob_len = eob_len_q[1];
  assign dht.uv_zrl     = zrl_code_q[1];
  assign dht.uv_zrl_len = zrl_len_q[1];

  assign s_tready = rdy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
